// File: rtl/multicycle_addsub.sv
// WIDTH-bit adder/subtractor that processes CHUNK bits per clock, linked by a
// carry register, with valid/ready handshakes and carry/overflow/zero flags.
module multicycle_addsub #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q, s_q, s_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               carry_q, cout_q, ovf_q, zero_q;
  logic [CHUNK-1:0]   a_sl_s, b_sl_s;
  logic [CHUNK:0]     sum_s;
  logic               last_s, ovf_s;

  assign last_s = (cnt_q == CNT_W'(NCHUNK - 1));

  // Chunk adder: select the active slice of A and B', add with the carry register
  always_comb begin
    a_sl_s = '0;
    b_sl_s = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      a_sl_s = a_sl_s | (a_q[i*CHUNK +: CHUNK] & {CHUNK{cnt_q == CNT_W'(i)}});
      b_sl_s = b_sl_s | (b_q[i*CHUNK +: CHUNK] & {CHUNK{cnt_q == CNT_W'(i)}});
    end
    sum_s = {1'b0, a_sl_s} + {1'b0, b_sl_s} + {{CHUNK{1'b0}}, carry_q};
    s_d = s_q;
    for (int i = 0; i < NCHUNK; i++) begin
      s_d[i*CHUNK +: CHUNK] = (cnt_q == CNT_W'(i)) ? sum_s[CHUNK-1:0] : s_q[i*CHUNK +: CHUNK];
    end
    // Carry into the MSB is recovered as a^b^sum at that bit position.
    ovf_s = a_sl_s[CHUNK-1] ^ b_sl_s[CHUNK-1] ^ sum_s[CHUNK-1] ^ sum_s[CHUNK];
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) state_d = RUN;
        else          state_d = IDLE;
      end
      RUN: begin
        if (last_s) state_d = DONE;
        else        state_d = RUN;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
        else           state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Operand capture, chunk accumulation and flag capture on the final chunk
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b ^ {WIDTH{sub}};
            carry_q <= sub;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          s_q     <= s_d;
          carry_q <= sum_s[CHUNK];
          cnt_q   <= cnt_q + CNT_W'(1);
          if (last_s) begin
            cout_q <= sum_s[CHUNK];
            ovf_q  <= ovf_s;
            zero_q <= (s_d == '0);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule

// File: doc/multicycle_addsub.md
Name: multicycle_addsub

Overview:
- Parametrised, multi-cycle successor to the 4-bit ripple-carry adder/subtractor.
- Computes a+b or a−b on WIDTH-bit operands, CHUNK bits per clock, with a carry register linking the chunks.
- Uses a valid/ready handshake on both input and output, and reports carry-out, signed overflow and zero flags.
- Sits between an operand source and a result consumer in the lab datapath, where a full-width combinational carry chain would be too long.

Parameters:
- WIDTH, 8, operand/result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 2, bits added per clock; CHUNK=WIDTH gives a single-cycle add.
- NCHUNK (localparam), WIDTH/CHUNK, number of RUN cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operands and mode valid.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0 = add, 1 = subtract (a−b).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- s  output  WIDTH  sum/difference, modulo 2^WIDTH.
- cout  output  1  carry out of the MSB; for subtract, 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.
- zero  output  1  s == 0.

Behaviour:
- Reset: one clock, all synchronous; reset is sampled only on clk rising edge with rst_n=0, which is the fixed decision for this block.
  - Outputs after reset: in_ready=1, out_valid=0, s=0, cout=0, ovf=0, zero=0.
  - State returns to IDLE; chunk counter and carry register cleared.
- State IDLE:
  - in_ready=1.
  - On in_valid && in_ready at an edge: latch a, latch (b XOR {WIDTH{sub}}), set carry=sub, cnt=0, go to RUN.
- State RUN:
  - in_ready=0.
  - Each edge adds bit slice [cnt*CHUNK +: CHUNK] of A, B' and carry, writes that slice of s, updates carry, and increments cnt.
  - On the edge where cnt==NCHUNK−1, capture the following, then go to DONE:
    - cout = final carry;
    - ovf = carry-into-MSB XOR carry-out-of-MSB;
    - zero = (full result == 0).
- State DONE:
  - out_valid=1, in_ready=0.
  - s and flags held stable.
  - On out_valid && out_ready: go to IDLE and drop out_valid; s and flags keep their last values.
- Latency: operation accepted at edge k gives out_valid=1 after edge k+NCHUNK. With defaults this is 4 cycles.
- Throughput: one operation per NCHUNK+2 cycles minimum. No overlap between operations (in_ready=0 outside IDLE).
- Intermediate values:
  - s may show partial results during RUN; consumers use s only when out_valid=1.
  - ovf, cout and zero do not change during RUN until the final chunk.
- Boundary conditions:
  - in_valid in RUN/DONE is ignored; a, b and sub are not sampled.
  - Operand changes after acceptance have no effect.
  - out_ready held low: remain in DONE indefinitely with outputs stable.
  - rst_n=0 at any state, including mid-RUN or in DONE: the reset values above apply at that edge and the operation is discarded.
  - rst_n=0 has priority over every handshake at that edge.
  - CHUNK=WIDTH: RUN lasts exactly one cycle.
  - Arithmetic is modulo 2^WIDTH; wrap-around is reported only through cout/ovf.

Test Plan (WIDTH=8, CHUNK=2):
- Reset, then a=0, b=0, sub=0 -> s=8'h00, cout=0, ovf=0, zero=1; out_valid rises exactly 4 edges after acceptance.
- Add 100+27 -> s=8'd127, ovf=0, cout=0. Then 100+28 -> s=8'h80, ovf=1, cout=0, zero=0.
- Add 8'hFF+8'h01 -> s=8'h00, cout=1, ovf=0, zero=1.
- Subtract:
  - 5−7 -> s=8'hFE, cout=0, ovf=0.
  - 8'h80−8'h01 -> s=8'h7F, cout=1, ovf=1.
  - 9−9 -> s=0, cout=1, zero=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE and drive in_valid=1 with new operands -> s and flags unchanged, in_ready=0, second operation not accepted. Then out_ready=1 -> IDLE, in_ready=1, and the second operation is accepted only afterwards.
- Reset mid-RUN: assert rst_n=0 on the 2nd RUN edge -> next cycle in_ready=1, out_valid=0, s=0. A following 3+4 completes with s=8'd7 and normal latency.
